// File: rtl/ex_stage.sv
// Purpose : MIPS execute stage. ALU, beq resolution, HI/LO and an iterative multiplier feed the EX/MEM register.
// Latency : one negedge from the ID/EX inputs to the EX/MEM outputs; mult/multu take MUL_CYCLES edges after start.
// Backpr. : stall_out freezes IF/ID/ID-EX while a mult/multu/mfhi/mflo waits on a busy multiplier; EX/MEM gets bubbles.
//
// Ports:
//   clk, rst_n                 pipeline clock (negedge-updated state), async active-low reset
//   PC, Rt, Rd, imm16          instruction fields from ID/EX
//   busA, busB                 register operands
//   ExtOp..RegWr, ALUop, func  decoded control
//   flush                      turn the instruction in EX into a bubble
//   *_out                      EX/MEM register contents
//   busy                       multiplier running
//   stall_out                  combinational hold request for upstream registers
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [15:0] imm16,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        ExtOp,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic        R_type,
  input  logic        MemWr,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        RegWr,
  input  logic [2:0]  ALUop,
  input  logic [5:0]  func,
  input  logic        flush,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  wr_reg_out,
  output logic [31:0] branch_target_out,
  output logic        branch_taken_out,
  output logic        MemWr_out,
  output logic        MemtoReg_out,
  output logic        RegWr_out,
  output logic        busy,
  output logic        stall_out
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110, F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;

  logic [31:0] hi_q, lo_q;
  logic [63:0] mcand_q, acc_q;
  logic [31:0] mplier_q;
  logic        mneg_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] ext, sext, b_op, alu_res, a_mag, b_mag;
  logic [63:0] acc_nxt, prod;
  logic        is_mul, is_hilo, mul_start, bubble, signed_mul;

  assign sext = {{16{imm16[15]}}, imm16};
  assign ext  = ExtOp ? sext : {16'b0, imm16};
  assign b_op = ALUSrc ? ext : busB;

  assign is_mul    = (func == F_MULT) || (func == F_MULTU);
  assign is_hilo   = is_mul || (func == F_MFHI) || (func == F_MFLO);
  assign stall_out = busy && R_type && is_hilo;

  // flush cancels a start; stall already implies busy, so no start then either.
  assign mul_start = !flush && !busy && R_type && is_mul;
  // mult/multu carries no register write of its own, so it always retires as a bubble.
  assign bubble    = flush || stall_out || (R_type && is_mul);

  // Signed multiply runs on magnitudes; the sign is applied to the 64-bit product at the end.
  assign signed_mul = (func == F_MULT);
  assign a_mag = (signed_mul && busA[31]) ? (~busA + 32'd1) : busA;
  assign b_mag = (signed_mul && busB[31]) ? (~busB + 32'd1) : busB;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign prod    = mneg_q ? (~acc_nxt + 64'd1) : acc_nxt;

  always_comb begin
    alu_res = 32'd0;
    if (R_type) begin
      case (func)
        F_ADD, F_ADDU: alu_res = busA + b_op;
        F_SUB, F_SUBU: alu_res = busA - b_op;
        F_AND:         alu_res = busA & b_op;
        F_OR:          alu_res = busA | b_op;
        F_XOR:         alu_res = busA ^ b_op;
        F_SLT:         alu_res = {31'd0, $signed(busA) < $signed(b_op)};
        F_SLTU:        alu_res = {31'd0, busA < b_op};
        F_MFHI:        alu_res = hi_q;
        F_MFLO:        alu_res = lo_q;
        default:       alu_res = 32'd0;
      endcase
    end else begin
      case (ALUop)
        3'b000:  alu_res = busA + b_op;
        3'b001:  alu_res = busA - b_op;
        3'b010:  alu_res = busA | b_op;
        3'b011:  alu_res = busA & b_op;
        3'b100:  alu_res = {31'd0, $signed(busA) < $signed(b_op)};
        3'b101:  alu_res = {31'd0, busA < b_op};
        3'b110:  alu_res = {imm16, 16'b0};
        default: alu_res = busA ^ b_op;
      endcase
    end
  end

  // Multiplier and HI/LO.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      mcand_q  <= 64'd0;
      acc_q    <= 64'd0;
      mplier_q <= 32'd0;
      mneg_q   <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
    end else if (busy) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
        hi_q  <= prod[63:32];
        lo_q  <= prod[31:0];
        busy  <= 1'b0;
        cnt_q <= '0;
      end
    end else if (mul_start) begin
      mcand_q  <= {32'd0, a_mag};
      mplier_q <= b_mag;
      acc_q    <= 64'd0;
      mneg_q   <= signed_mul && (busA[31] ^ busB[31]);
      cnt_q    <= '0;
      busy     <= 1'b1;
    end
  end

  // EX/MEM register; data fields always load, control fields are zeroed on a bubble.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out    <= 32'd0;
      store_data_out    <= 32'd0;
      wr_reg_out        <= 5'd0;
      branch_target_out <= 32'd0;
      branch_taken_out  <= 1'b0;
      MemWr_out         <= 1'b0;
      MemtoReg_out      <= 1'b0;
      RegWr_out         <= 1'b0;
    end else begin
      alu_result_out    <= alu_res;
      store_data_out    <= busB;
      wr_reg_out        <= RegDst ? Rd : Rt;
      branch_target_out <= PC + 32'd4 + {sext[29:0], 2'b00};
      branch_taken_out  <= !bubble && Branch && (busA == busB);
      MemWr_out         <= !bubble && MemWr;
      MemtoReg_out      <= !bubble && MemtoReg;
      RegWr_out         <= !bubble && RegWr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Purpose : directed-vector bench for ex_stage (ALU, branch, multiplier interlock, flush, reset).
// Latency : inputs driven just after a negedge, outputs sampled 1 time unit after the next negedge.
// Backpr. : stall waits are bounded so the run always reaches its summary line.
module tb_ex_stage;

  logic        clk, rst_n;
  logic [31:0] PC;
  logic [4:0]  Rt, Rd;
  logic [15:0] imm16;
  logic [31:0] busA, busB;
  logic        ExtOp, ALUSrc, RegDst, R_type, MemWr, Branch, MemtoReg, RegWr;
  logic [2:0]  ALUop;
  logic [5:0]  func;
  logic        flush;
  logic [31:0] alu_result_out, store_data_out, branch_target_out;
  logic [4:0]  wr_reg_out;
  logic        branch_taken_out, MemWr_out, MemtoReg_out, RegWr_out, busy, stall_out;

  int vectors = 0;
  int errors  = 0;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .Rt(Rt), .Rd(Rd), .imm16(imm16),
    .busA(busA), .busB(busB), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .R_type(R_type), .MemWr(MemWr), .Branch(Branch), .MemtoReg(MemtoReg),
    .RegWr(RegWr), .ALUop(ALUop), .func(func), .flush(flush),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .wr_reg_out(wr_reg_out), .branch_target_out(branch_target_out),
    .branch_taken_out(branch_taken_out), .MemWr_out(MemWr_out),
    .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out), .busy(busy),
    .stall_out(stall_out)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic nop;
    PC = 32'd0; Rt = 5'd0; Rd = 5'd0; imm16 = 16'd0; busA = 32'd0; busB = 32'd0;
    ExtOp = 0; ALUSrc = 0; RegDst = 0; R_type = 0; MemWr = 0; Branch = 0;
    MemtoReg = 0; RegWr = 0; ALUop = 3'd0; func = 6'd0; flush = 0;
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    nop;
    R_type = 1; RegDst = 1; RegWr = 1; func = f; busA = a; busB = b; Rd = d; Rt = 5'd31;
  endtask

  task automatic set_i(input logic [2:0] op, input logic [31:0] a, input logic [15:0] imm,
                       input logic ext, input logic [4:0] t);
    nop;
    ALUop = op; busA = a; imm16 = imm; ExtOp = ext; ALUSrc = 1; RegWr = 1; Rt = t; Rd = 5'd30;
  endtask

  // Clocks while stall_out is high (bounded); reports edge count and whether any
  // stalled edge leaked a register write into EX/MEM.
  task automatic wait_stall(output int n, output logic leaked);
    n = 0;
    leaked = 1'b0;
    #1;
    while (stall_out === 1'b1 && n < 40) begin
      tick;
      n++;
      if (RegWr_out !== 1'b0) leaked = 1'b1;
    end
  endtask

  task automatic test_reset;
    nop;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_result_out, store_data_out, wr_reg_out, branch_target_out, branch_taken_out,
         MemWr_out, MemtoReg_out, RegWr_out, busy, stall_out} !== '0) begin
      errors++;
      $display("FAIL reset_state got alu=%h sd=%h wr=%h bt=%h tk=%b busy=%b want all 0",
               alu_result_out, store_data_out, wr_reg_out, branch_target_out,
               branch_taken_out, busy);
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    set_r(6'b100000, 32'h7FFFFFFF, 32'h1, 5'd5);
    tick;
    vectors++;
    if ({alu_result_out, wr_reg_out, RegWr_out, MemtoReg_out} !== {32'h80000000, 5'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_wrap got %h r%0d wr=%b want 80000000 r5 wr=1", alu_result_out, wr_reg_out, RegWr_out);
    end
    set_r(6'b101011, 32'h1, 32'hFFFFFFFF, 5'd6);
    tick;
    vectors++;
    if (alu_result_out !== 32'h1) begin
      errors++; $display("FAIL sltu got %h want 00000001", alu_result_out);
    end
    set_r(6'b101010, 32'h1, 32'hFFFFFFFF, 5'd7);
    tick;
    vectors++;
    if (alu_result_out !== 32'h0) begin
      errors++; $display("FAIL slt got %h want 00000000", alu_result_out);
    end
    set_r(6'b000111, 32'h5, 32'h5, 5'd7);
    tick;
    vectors++;
    if (alu_result_out !== 32'h0) begin
      errors++; $display("FAIL unknown_func got %h want 00000000", alu_result_out);
    end
    set_i(3'b110, 32'hFFFFFFFF, 16'h1234, 1'b0, 5'd8);
    tick;
    vectors++;
    if ({alu_result_out, wr_reg_out} !== {32'h12340000, 5'd8}) begin
      errors++; $display("FAIL lui got %h r%0d want 12340000 r8", alu_result_out, wr_reg_out);
    end
    set_i(3'b010, 32'h12340000, 16'h8000, 1'b0, 5'd9);
    tick;
    vectors++;
    if ({alu_result_out, wr_reg_out} !== {32'h12348000, 5'd9}) begin
      errors++; $display("FAIL ori_zext got %h r%0d want 12348000 r9", alu_result_out, wr_reg_out);
    end
    set_i(3'b001, 32'd10, 16'hFFFF, 1'b1, 5'd4);
    tick;
    vectors++;
    if (alu_result_out !== 32'd11) begin
      errors++; $display("FAIL sub_sext got %h want 0000000b", alu_result_out);
    end
  endtask

  task automatic test_branch;
    nop;
    Branch = 1; PC = 32'h100; imm16 = 16'hFFFF; busA = 32'hABCD; busB = 32'hABCD;
    tick;
    vectors++;
    if ({branch_target_out, branch_taken_out, RegWr_out} !== {32'h100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL beq_taken got tgt=%h tk=%b want tgt=00000100 tk=1", branch_target_out, branch_taken_out);
    end
    busB = 32'hABCE;
    tick;
    vectors++;
    if ({branch_target_out, branch_taken_out} !== {32'h100, 1'b0}) begin
      errors++;
      $display("FAIL beq_not_taken got tgt=%h tk=%b want tgt=00000100 tk=0", branch_target_out, branch_taken_out);
    end
  endtask

  task automatic test_mult_signed;
    int n;
    logic leaked;
    set_r(6'b011000, 32'hFFFFFFFD, 32'd5, 5'd3);
    tick;
    vectors++;
    if ({busy, RegWr_out} !== 2'b10) begin
      errors++; $display("FAIL mult_start got busy=%b wr=%b want busy=1 wr=0", busy, RegWr_out);
    end
    set_r(6'b010010, 32'd0, 32'd0, 5'd10);
    wait_stall(n, leaked);
    vectors++;
    if (n != 32 || leaked) begin
      errors++; $display("FAIL mult_stall got %0d edges leak=%b want 32 edges leak=0", n, leaked);
    end
    tick;
    vectors++;
    if ({alu_result_out, wr_reg_out, RegWr_out} !== {32'hFFFFFFF1, 5'd10, 1'b1}) begin
      errors++; $display("FAIL mult_lo got %h wr=%b want fffffff1 wr=1", alu_result_out, RegWr_out);
    end
    set_r(6'b010000, 32'd0, 32'd0, 5'd11);
    tick;
    vectors++;
    if (alu_result_out !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL mult_hi got %h want ffffffff", alu_result_out);
    end
  endtask

  task automatic test_multu;
    int n;
    logic leaked;
    set_r(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    tick;
    set_r(6'b010000, 32'd0, 32'd0, 5'd12);
    wait_stall(n, leaked);
    tick;
    vectors++;
    if (n != 32 || alu_result_out !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu_hi got %h after %0d stalls want fffffffe after 32", alu_result_out, n);
    end
    set_r(6'b010010, 32'd0, 32'd0, 5'd12);
    tick;
    vectors++;
    if (alu_result_out !== 32'h00000001) begin
      errors++; $display("FAIL multu_lo got %h want 00000001", alu_result_out);
    end
  endtask

  task automatic test_overlap;
    int n;
    logic leaked;
    set_r(6'b011001, 32'd6, 32'd7, 5'd3);
    tick;
    set_r(6'b100001, 32'd100, 32'd23, 5'd13);
    #1;
    vectors++;
    if (stall_out !== 1'b0) begin
      errors++; $display("FAIL overlap_add_stall got %b want 0", stall_out);
    end
    tick;
    vectors++;
    if ({alu_result_out, wr_reg_out, RegWr_out} !== {32'd123, 5'd13, 1'b1}) begin
      errors++; $display("FAIL overlap_add got %h r%0d wr=%b want 0000007b r13 wr=1", alu_result_out, wr_reg_out, RegWr_out);
    end
    set_i(3'b000, 32'h1000, 16'hFFFC, 1'b1, 5'd14);
    MemtoReg = 1;
    #1;
    vectors++;
    if (stall_out !== 1'b0) begin
      errors++; $display("FAIL overlap_lw_stall got %b want 0", stall_out);
    end
    tick;
    vectors++;
    if ({alu_result_out, wr_reg_out, MemtoReg_out, RegWr_out} !== {32'h00000FFC, 5'd14, 1'b1, 1'b1}) begin
      errors++; $display("FAIL overlap_lw got %h r%0d m2r=%b want 00000ffc r14 m2r=1", alu_result_out, wr_reg_out, MemtoReg_out);
    end
    set_r(6'b010010, 32'd0, 32'd0, 5'd15);
    wait_stall(n, leaked);
    tick;
    vectors++;
    if (n != 30 || alu_result_out !== 32'd42) begin
      errors++; $display("FAIL overlap_mflo got %h after %0d stalls want 0000002a after 30", alu_result_out, n);
    end
    // Second multiply presented while the first is still running.
    set_r(6'b011001, 32'h10000, 32'h10000, 5'd3);
    tick;
    set_r(6'b011000, 32'd2, 32'd3, 5'd3);
    wait_stall(n, leaked);
    vectors++;
    if (n != 32 || busy !== 1'b0 || leaked) begin
      errors++; $display("FAIL mult_mid_busy got %0d stalls busy=%b want 32 stalls busy=0", n, busy);
    end
    tick;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mult_mid_busy_start got busy=%b want 1", busy);
    end
    set_r(6'b010010, 32'd0, 32'd0, 5'd16);
    wait_stall(n, leaked);
    tick;
    vectors++;
    if (n != 32 || alu_result_out !== 32'd6) begin
      errors++; $display("FAIL second_mult_lo got %h after %0d stalls want 00000006 after 32", alu_result_out, n);
    end
    set_r(6'b010000, 32'd0, 32'd0, 5'd16);
    tick;
    vectors++;
    if (alu_result_out !== 32'd0) begin
      errors++; $display("FAIL second_mult_hi got %h want 00000000", alu_result_out);
    end
  endtask

  task automatic test_flush;
    int n;
    logic leaked;
    nop;
    MemWr = 1; ALUSrc = 1; ExtOp = 1; busA = 32'h200; busB = 32'hDEAD; imm16 = 16'h4;
    tick;
    vectors++;
    if ({MemWr_out, store_data_out, alu_result_out} !== {1'b1, 32'hDEAD, 32'h204}) begin
      errors++; $display("FAIL store got mw=%b sd=%h a=%h want mw=1 sd=0000dead a=00000204", MemWr_out, store_data_out, alu_result_out);
    end
    flush = 1;
    tick;
    vectors++;
    if (MemWr_out !== 1'b0) begin
      errors++; $display("FAIL flush_store got mw=%b want 0", MemWr_out);
    end
    set_r(6'b011000, 32'd3, 32'd3, 5'd3);
    tick;
    set_r(6'b010010, 32'd0, 32'd0, 5'd17);
    flush = 1;
    #1;
    vectors++;
    if (stall_out !== 1'b1) begin
      errors++; $display("FAIL flush_stall_req got %b want 1", stall_out);
    end
    tick;
    vectors++;
    if ({RegWr_out, busy} !== 2'b01) begin
      errors++; $display("FAIL flush_stall got wr=%b busy=%b want wr=0 busy=1", RegWr_out, busy);
    end
    flush = 0;
    wait_stall(n, leaked);
    tick;
    vectors++;
    if (n != 31 || alu_result_out !== 32'd9) begin
      errors++; $display("FAIL flush_no_abort got %h after %0d stalls want 00000009 after 31", alu_result_out, n);
    end
    set_r(6'b011000, 32'd4, 32'd4, 5'd3);
    flush = 1;
    tick;
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_mult got busy=%b want 0", busy);
    end
    set_r(6'b010010, 32'd0, 32'd0, 5'd18);
    tick;
    vectors++;
    if (alu_result_out !== 32'd9) begin
      errors++; $display("FAIL flush_mult_lo got %h want 00000009", alu_result_out);
    end
  endtask

  task automatic test_reset_mid;
    set_r(6'b100000, 32'd1, 32'd2, 5'd3);
    tick;
    set_r(6'b011000, 32'd5, 32'd5, 5'd3);
    tick;
    nop;
    tick; tick;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_result_out, store_data_out, wr_reg_out, branch_target_out, branch_taken_out,
         MemWr_out, MemtoReg_out, RegWr_out, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid got alu=%h sd=%h wr=%h bt=%h busy=%b want all 0",
               alu_result_out, store_data_out, wr_reg_out, branch_target_out, busy);
    end
    #1;
    rst_n = 1'b1;
    set_r(6'b010000, 32'd0, 32'd0, 5'd19);
    tick;
    vectors++;
    if ({alu_result_out, RegWr_out} !== {32'd0, 1'b1}) begin
      errors++; $display("FAIL reset_hi got %h wr=%b want 00000000 wr=1", alu_result_out, RegWr_out);
    end
    set_r(6'b010010, 32'd0, 32'd0, 5'd19);
    tick;
    vectors++;
    if (alu_result_out !== 32'd0) begin
      errors++; $display("FAIL reset_lo got %h want 00000000", alu_result_out);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branch;
    test_mult_signed;
    test_multu;
    test_overlap;
    test_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
